// File: rtl/and_gate_arbiter_pkg.sv
// Shared types and limits for the and_gate_arbiter controller.
package and_arb_pkg;

  localparam int unsigned MAX_NUM_REQ      = 16;
  localparam int unsigned MAX_GATE_LATENCY = 8;
  // Wide enough to hold the largest gate latency loaded into the wait counter.
  localparam int unsigned CNT_W            = $clog2(MAX_GATE_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/and_gate_arbiter_if.sv
// Requester-side request/response bundle for and_gate_arbiter.
interface and_gate_arbiter_if #(
  parameter int unsigned INPUT_WIDTH = 1,
  parameter int unsigned NUM_REQ     = 4
);

  logic [NUM_REQ-1:0]             req_valid_in;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_a_in;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_b_in;
  logic [NUM_REQ-1:0]             req_ready_out;
  logic [NUM_REQ-1:0]             rsp_valid_out;
  logic [NUM_REQ-1:0]             rsp_ready_in;
  logic [INPUT_WIDTH-1:0]         rsp_c_out;

  // Requester side
  modport master (
    output req_valid_in, req_a_in, req_b_in, rsp_ready_in,
    input  req_ready_out, rsp_valid_out, rsp_c_out
  );

  // Controller side
  modport slave (
    input  req_valid_in, req_a_in, req_b_in, rsp_ready_in,
    output req_ready_out, rsp_valid_out, rsp_c_out
  );

endinterface

// File: rtl/and_gate_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the requester at ptr wins first,
// then ascending indices with wrap-around.
module and_rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the pointer, take the first active request.
  always_comb begin
    logic              found;
    logic [IDX_W-1:0]  p;
    int unsigned       pos;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    p     = '0;
    pos   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = 32'(ptr) + off;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      p = IDX_W'(pos);
      if (!found && req[p]) begin
        found    = 1'b1;
        grant[p] = 1'b1;
        idx      = p;
      end
    end
  end

endmodule

// File: rtl/and_gate_arbiter.sv
// Shares one registered AND gate among NUM_REQ requesters: round-robin
// grant, wait out the gate latency, return the result with valid/ready.
// Optional feature: define AND_ARB_TXN_CNT_EN to add a saturating
// response-handshake counter on txn_count_out.
module and_gate_arbiter
  import and_arb_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = 1,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GATE_LATENCY = 1
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  and_gate_arbiter_if.slave      bus,
  output logic [INPUT_WIDTH-1:0] gate_a_out,
  output logic [INPUT_WIDTH-1:0] gate_b_out,
  input  logic [INPUT_WIDTH-1:0] gate_c_in,
`ifdef AND_ARB_TXN_CNT_EN
  output logic [15:0]            txn_count_out,
`endif
  output logic                   busy_out
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject out-of-range configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > MAX_NUM_REQ) begin : g_bad_num_req
    $error("and_gate_arbiter: NUM_REQ out of range");
  end
  if (GATE_LATENCY < 1 || GATE_LATENCY > MAX_GATE_LATENCY) begin : g_bad_latency
    $error("and_gate_arbiter: GATE_LATENCY out of range");
  end

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INPUT_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [NUM_REQ-1:0]     rsp_v_q, rsp_v_d;
  logic                   busy_q, busy_d;
  logic [NUM_REQ-1:0]     rr_grant;
  logic [IDX_W-1:0]       rr_idx;
  logic                   req_hs;
  logic                   rsp_hs;

  logic [INPUT_WIDTH-1:0] req_a [NUM_REQ];
  logic [INPUT_WIDTH-1:0] req_b [NUM_REQ];

  // Unpack the flat operand buses into per-requester slices.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_a[i] = bus.req_a_in[i*INPUT_WIDTH +: INPUT_WIDTH];
    assign req_b[i] = bus.req_b_in[i*INPUT_WIDTH +: INPUT_WIDTH];
  end

  and_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (bus.req_valid_in),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // Grant is offered only while idle; it may follow the requester's own valid.
  assign bus.req_ready_out = (state_q == IDLE) ? rr_grant : '0;
  assign req_hs            = |(bus.req_valid_in & bus.req_ready_out);
  assign rsp_hs            = (state_q == RESP) && bus.rsp_ready_in[gidx_q];

  assign bus.rsp_valid_out = rsp_v_q;
  assign bus.rsp_c_out     = c_q;
  assign gate_a_out        = a_q;
  assign gate_b_out        = b_q;
  assign busy_out          = busy_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    rsp_v_d = rsp_v_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          gidx_d  = rr_idx;
          a_d     = req_a[rr_idx];
          b_d     = req_b[rr_idx];
          cnt_d   = CNT_W'(GATE_LATENCY);
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          c_d     = gate_c_in;
          rsp_v_d = NUM_REQ'(1) << gidx_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_v_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      rsp_v_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      rsp_v_q <= rsp_v_d;
      busy_q  <= busy_d;
    end
  end

`ifdef AND_ARB_TXN_CNT_EN
  logic [15:0] txn_q, txn_d;

  // Saturating count of completed response handshakes.
  always_comb begin
    txn_d = txn_q;
    if (rsp_hs && (txn_q != 16'hFFFF)) txn_d = txn_q + 16'd1;
  end

  // Transaction counter register.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) txn_q <= '0;
    else             txn_q <= txn_d;
  end

  assign txn_count_out = txn_q;
`endif

endmodule

// File: tb/tb_and_gate_arbiter.sv
// Self-checking bench for and_gate_arbiter with a behavioural gate model.
module tb_and_gate_arbiter;

  localparam int unsigned W = 1;
  localparam int unsigned N = 4;
`ifdef AND_ARB_TXN_CNT_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  and_gate_arbiter_if #(.INPUT_WIDTH(W), .NUM_REQ(N)) bus ();

  logic [W-1:0] gate_a, gate_b, gate_c;
  logic         busy;
`ifdef AND_ARB_TXN_CNT_EN
  logic [15:0]  txn_count;
`endif

  and_gate_arbiter #(.INPUT_WIDTH(W), .NUM_REQ(N), .GATE_LATENCY(LAT)) dut (
    .clock_in      (clk),
    .reset_n_in    (rst_n),
    .bus           (bus),
    .gate_a_out    (gate_a),
    .gate_b_out    (gate_b),
    .gate_c_in     (gate_c),
`ifdef AND_ARB_TXN_CNT_EN
    .txn_count_out (txn_count),
`endif
    .busy_out      (busy)
  );

  // Registered AND gate with LAT edges from input change to valid output.
  logic [W-1:0] gpipe [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) gpipe[i] <= '0;
    end else begin
      gpipe[0] <= gate_a & gate_b;
      for (int i = 1; i < LAT; i++) gpipe[i] <= gpipe[i-1];
    end
  end
  assign gate_c = gpipe[LAT-1];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int           idx;
    logic [W-1:0] c;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int           idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: latency of each response and its payload.
  logic rsp_active = 1'b0;
  int   acc_cyc    = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      rsp_active = 1'b0;
    end else begin
      if (|(bus.req_valid_in & bus.req_ready_out)) acc_cyc = cyc;
      if (|bus.rsp_valid_out && !rsp_active) begin
        rsp_active = 1'b1;
        chk("rsp_latency", 32'(cyc - acc_cyc), LAT + 2);
      end
      if (|(bus.rsp_valid_out & bus.rsp_ready_in)) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(bus.rsp_valid_out), 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid_onehot", 32'(bus.rsp_valid_out), 32'(1) << e.idx);
          chk("rsp_c", 32'(bus.rsp_c_out), 32'(e.c));
        end
        rsp_active = 1'b0;
      end
    end
  end

  task automatic wait_accept(input int idx);
    logic ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.req_valid_in[idx] && bus.req_ready_out[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_seen", 32'(ok), 1);
    @(posedge clk); #1;
    bus.req_valid_in[idx] = 1'b0;
  endtask

  task automatic send(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic chk_rdy);
    exp_t e;
    e.idx = idx;
    e.c   = c;
    exp_q.push_back(e);
    bus.req_valid_in[idx]     = 1'b1;
    bus.req_a_in[idx*W +: W]  = a;
    bus.req_b_in[idx*W +: W]  = b;
    if (chk_rdy) begin
      #1;
      chk("ready_same_cycle", 32'(bus.req_ready_out), 32'(1) << idx);
    end
    wait_accept(idx);
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t tv[5];
    int   rr_idx[5];
    logic rr_c[5];
    int   prev;
    logic ok;
    logic [W-1:0] ra, rb;

    tv[0] = '{1, 1'b1, 1'b1, 1'b1};
    tv[1] = '{0, 1'b0, 1'b0, 1'b0};
    tv[2] = '{0, 1'b1, 1'b0, 1'b0};
    tv[3] = '{0, 1'b0, 1'b1, 1'b0};
    tv[4] = '{0, 1'b1, 1'b1, 1'b1};
    rr_idx = '{0, 1, 2, 3, 0};
    rr_c   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    bus.req_valid_in = '0;
    bus.req_a_in     = '0;
    bus.req_b_in     = '0;
    bus.rsp_ready_in = '1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gate_a", 32'(gate_a), 0);
    chk("rst_gate_b", 32'(gate_b), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_out), 0);
    chk("rst_rsp_c", 32'(bus.rsp_c_out), 0);
`ifdef AND_ARB_TXN_CNT_EN
    chk("rst_txn_count", 32'(txn_count), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request, then truth table through requester 0
    for (int i = 0; i < 5; i++) begin
      send(tv[i].idx, tv[i].a, tv[i].b, tv[i].c, (i == 0));
      wait_idle();
    end

    // Reset while waiting on the gate
    send(2, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("busy_in_wait", 32'(busy), 1);
    chk("gate_a_in_wait", 32'(gate_a), 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_gate_a", 32'(gate_a), 0);
    chk("rstw_gate_b", 32'(gate_b), 0);
    chk("rstw_rsp_valid", 32'(bus.rsp_valid_out), 0);
    chk("rstw_rsp_c", 32'(bus.rsp_c_out), 0);
    chk("rstw_req_ready", 32'(bus.req_ready_out), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("no_rsp_after_reset", 32'(bus.rsp_valid_out), 0);

    // Round robin with every requester valid and responses accepted at once
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      exp_t e;
      e.idx = rr_idx[k];
      e.c   = rr_c[k];
      exp_q.push_back(e);
    end
    bus.req_a_in     = 4'b1011;
    bus.req_b_in     = 4'b1110;
    bus.req_valid_in = '1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 64; t++) begin
        @(negedge clk);
        if (|(bus.req_valid_in & bus.req_ready_out)) begin
          ok = 1'b1;
          break;
        end
      end
      chk("rr_grant", 32'(bus.req_ready_out), 32'(1) << rr_idx[k]);
      if (k > 0 && ok) chk("rr_spacing", 32'(cyc - prev), LAT + 3);
      prev = cyc;
      @(posedge clk); #1;
      if (k == 4) bus.req_valid_in = '0;
    end
    wait_idle();

    // Response backpressure with another requester waiting
    bus.rsp_ready_in = '0;
    send(3, 1'b1, 1'b1, 1'b1, 1'b0);
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (|bus.rsp_valid_out) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_rsp_seen", 32'(ok), 1);
    begin
      exp_t e;
      e.idx = 0;
      e.c   = 1'b0;
      exp_q.push_back(e);
    end
    bus.req_a_in[0]     = 1'b1;
    bus.req_b_in[0]     = 1'b0;
    bus.req_valid_in[0] = 1'b1;
    bus.rsp_ready_in    = 4'b0111;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid_out), 32'b1000);
      chk("bp_rsp_c", 32'(bus.rsp_c_out), 1);
      chk("bp_req_ready", 32'(bus.req_ready_out), 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready_in = '1;
    @(posedge clk); #1;
    chk("bp_done_valid", 32'(bus.rsp_valid_out), 0);
    chk("bp_done_busy", 32'(busy), 0);
    wait_accept(0);
    wait_idle();

    // Ten back-to-back transactions from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
`ifdef AND_ARB_TXN_CNT_EN
    chk("txn_count_reset", 32'(txn_count), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int t = 0; t < 10; t++) begin
      ra = W'($urandom_range(0, 1));
      rb = W'($urandom_range(0, 1));
      send(t % N, ra, rb, ra & rb, 1'b0);
      wait_idle();
    end
`ifdef AND_ARB_TXN_CNT_EN
    chk("txn_count_10", 32'(txn_count), 10);
`endif
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
